// File: rtl/stack_pkg.sv
// stack_pkg: shared opcodes, FSM state encoding and stack register codes
// for the stack_unit engine and its per-stack banks.
package stack_pkg;

    // Command opcodes carried on op_code
    localparam logic [2:0] OP_POP   = 3'b001;
    localparam logic [2:0] OP_PUSH  = 3'b010;
    localparam logic [2:0] OP_PUSHI = 3'b011;
    localparam logic [2:0] OP_GSA   = 3'b100;
    localparam logic [2:0] OP_PEEK  = 3'b101;
    localparam logic [2:0] OP_CLR   = 3'b110;

    // Control FSM of stack_unit
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Register-file codes that name stacks A/B/C
    localparam logic [7:0] STACK_CODE_A = 8'h20;
    localparam logic [7:0] STACK_CODE_B = 8'h40;
    localparam logic [7:0] STACK_CODE_C = 8'h60;

endpackage

// File: rtl/stack_bank.sv
// stack_bank: one LIFO stack (DEPTH x DATA_W RAM plus occupancy count).
// Ports:
//   clk, rst        - clock, synchronous active-high reset (count/top only)
//   push/pop/clr    - single-cycle strobes; push ignored when full,
//                     pop ignored when empty, clr has priority
//   rd_en           - capture current top into top_data (0 when empty)
//   push_data       - value written on push
//   top_data        - registered top-of-stack read
//   count           - live occupancy, full/empty derived from it
module stack_bank
    import stack_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     top_idx;

    // DEPTH is a power of two, so the low AW bits of count address the
    // next free slot; wrap of wr_idx at full lands top_idx on DEPTH-1.
    assign wr_idx  = count[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            top_data <= '0;
        end else begin
            if (clr)
                count <= '0;
            else if (push && !full)
                count <= count + CNT_W'(1);
            else if (pop && !empty)
                count <= count - CNT_W'(1);

            // Read uses the pre-pop count, so a POP sees its own top entry
            if (rd_en)
                top_data <= empty ? '0 : mem[top_idx];
        end
    end

endmodule

// File: rtl/stack_unit.sv
// stack_unit: multi-stack engine. Accepts POP/PUSH/PUSHI/GSA/CLR (and PEEK
// when built with STACK_PEEK_EN defined) over a valid/ready command port and
// returns register write-backs over a valid/ready write-back port.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   op_valid/op_ready              - command handshake
//   op_code, op_stack_id           - opcode and target stack (1..STACK_COUNT)
//   op_value                       - PUSH/PUSHI data
//   op_dest_code                   - write-back register code
//   wb_valid/wb_ready              - write-back handshake
//   wb_code, wb_value              - write-back payload, stable while pending
//   count_flat                     - all stack counts, stack 1 at LSBs
//   err_overflow/err_underflow     - sticky error flags
//   err_clear                      - clears both flags (a same-cycle set wins)
// Build option: STACK_PEEK_EN enables opcode 101 as PEEK; otherwise no-op.
module stack_unit
    import stack_pkg::*;
#(
    parameter int STACK_COUNT = 3,
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 32,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [2:0]                   op_code,
    input  logic [2:0]                   op_stack_id,
    input  logic [DATA_W-1:0]            op_value,
    input  logic [7:0]                   op_dest_code,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [7:0]                   wb_code,
    output logic [DATA_W-1:0]            wb_value,
    output logic [STACK_COUNT*CNT_W-1:0] count_flat,
    output logic                         err_overflow,
    output logic                         err_underflow,
    input  logic                         err_clear
);

    state_t state, state_nxt;

    logic [STACK_COUNT-1:0]             sel;
    logic [STACK_COUNT-1:0]             sel_q;
    logic [STACK_COUNT-1:0][DATA_W-1:0] top_data;
    logic [STACK_COUNT-1:0][CNT_W-1:0]  cnt;
    logic [STACK_COUNT-1:0]             full, empty;
    logic [STACK_COUNT-1:0]             push_s, pop_s, clr_s, rd_s;

    logic              sel_full, sel_empty;
    logic [CNT_W-1:0]  sel_cnt;
    logic [DATA_W-1:0] rd_mux;
    logic              acc;
    logic              is_pop, is_push, is_gsa, is_clr, is_peek, is_read;

    assign op_ready = (state == ST_IDLE) && !rst;
    assign wb_valid = (state == ST_WB);

    assign is_pop  = (op_code == OP_POP);
    assign is_push = (op_code == OP_PUSH) || (op_code == OP_PUSHI);
    assign is_gsa  = (op_code == OP_GSA);
    assign is_clr  = (op_code == OP_CLR);
`ifdef STACK_PEEK_EN
    assign is_peek = (op_code == OP_PEEK);
`else
    assign is_peek = 1'b0;
`endif
    assign is_read = is_pop || is_peek;

    // One-hot stack decode; ID 0 or beyond STACK_COUNT selects nothing,
    // which turns the command into a silent no-op.
    always_comb begin
        sel       = '0;
        sel_full  = 1'b0;
        sel_empty = 1'b0;
        sel_cnt   = '0;
        for (int i = 0; i < STACK_COUNT; i++) begin
            sel[i] = (op_stack_id == 3'(i + 1));
            if (sel[i]) begin
                sel_full  = full[i];
                sel_empty = empty[i];
                sel_cnt   = cnt[i];
            end
        end
    end

    assign acc = op_valid && op_ready && (|sel);

    assign push_s = {STACK_COUNT{acc && is_push}} & sel;
    assign pop_s  = {STACK_COUNT{acc && is_pop}}  & sel;
    assign clr_s  = {STACK_COUNT{acc && is_clr}}  & sel;
    assign rd_s   = {STACK_COUNT{acc && is_read}} & sel;

    for (genvar g = 0; g < STACK_COUNT; g++) begin : g_bank
        stack_bank #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .push      (push_s[g]),
            .pop       (pop_s[g]),
            .clr       (clr_s[g]),
            .rd_en     (rd_s[g]),
            .push_data (op_value),
            .top_data  (top_data[g]),
            .count     (cnt[g]),
            .full      (full[g]),
            .empty     (empty[g])
        );
    end

    assign count_flat = cnt;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < STACK_COUNT; i++)
            if (sel_q[i])
                rd_mux = rd_mux | top_data[i];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (acc && is_read)
                    state_nxt = ST_READ;
                else if (acc && is_gsa)
                    state_nxt = ST_WB;
            end
            ST_READ: state_nxt = ST_WB;
            ST_WB: begin
                if (wb_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write-back payload and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_code       <= '0;
            wb_value      <= '0;
            sel_q         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (acc && (is_read || is_gsa)) begin
                wb_code <= op_dest_code;
                sel_q   <= sel;
            end
            // GSA reports the count as seen on its own accept edge
            if (acc && is_gsa)
                wb_value <= DATA_W'(sel_cnt);
            else if (state == ST_READ)
                wb_value <= rd_mux;

            if (acc && is_push && sel_full)
                err_overflow <= 1'b1;
            else if (err_clear)
                err_overflow <= 1'b0;

            if (acc && is_read && sel_empty)
                err_underflow <= 1'b1;
            else if (err_clear)
                err_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: randomized plus directed stimulus against a LIFO reference
// model; expected write-backs are queued at accept time and consumed by an
// independent write-back monitor.
module tb_stack_unit;

    localparam int SC = 3;
    localparam int DEPTH = 16;
    localparam int DW = 32;
    localparam int CW = 5;

`ifdef STACK_PEEK_EN
    localparam bit PEEK_EN = 1'b1;
`else
    localparam bit PEEK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [2:0]      op_code = '0;
    logic [2:0]      op_stack_id = '0;
    logic [DW-1:0]   op_value = '0;
    logic [7:0]      op_dest_code = '0;
    logic            wb_valid;
    logic            wb_ready = 1'b1;
    logic [7:0]      wb_code;
    logic [DW-1:0]   wb_value;
    logic [SC*CW-1:0] count_flat;
    logic            err_overflow, err_underflow;
    logic            err_clear = 1'b0;

    stack_unit #(.STACK_COUNT(SC), .DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_stack_id(op_stack_id), .op_value(op_value),
        .op_dest_code(op_dest_code), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_code(wb_code), .wb_value(wb_value), .count_flat(count_flat),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays holding each stack bottom-to-top
    logic [DW-1:0] mdl [SC][DEPTH];
    int            msz [SC];
    bit            m_of, m_uf;
    logic [7:0]    exp_code [$];
    logic [DW-1:0] exp_val  [$];

    int nchk = 0;
    int npass = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [SC*CW-1:0] exp_flat();
        logic [SC*CW-1:0] f;
        f = '0;
        for (int i = 0; i < SC; i++) f[i*CW +: CW] = CW'(msz[i]);
        return f;
    endfunction

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0: wb_ready = 1'b1;
            1: wb_ready = ($urandom_range(0, 9) < 6);
            default: wb_ready = 1'b0;
        endcase
    end

    // Write-back monitor
    bit            held = 1'b0;
    logic [7:0]    h_code;
    logic [DW-1:0] h_val;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (wb_valid) begin
            if (held) chk("wb_stable", {wb_code, wb_value}, {h_code, h_val});
            if (wb_ready) begin
                held = 1'b0;
                if (exp_code.size() == 0) begin
                    chk("wb_unexpected", {wb_code, wb_value}, 64'hDEAD);
                end else begin
                    chk("wb_code", wb_code, exp_code.pop_front());
                    chk("wb_value", wb_value, exp_val.pop_front());
                end
            end else begin
                held = 1'b1;
                h_code = wb_code;
                h_val = wb_value;
            end
        end else begin
            held = 1'b0;
        end
    end

    // Apply the architectural effect of an accepted command to the model
    task automatic model_accept(input logic [2:0] op, input logic [2:0] id, input logic [DW-1:0] val,
                                input logic [7:0] dest, input bit clr_e, output int lat);
        bit set_of = 0, set_uf = 0;
        int s;
        lat = 0;
        if (id >= 1 && id <= SC) begin
            s = int'(id) - 1;
            if (op == 3'b001 || (op == 3'b101 && PEEK_EN)) begin
                lat = 2;
                exp_code.push_back(dest);
                if (msz[s] == 0) begin
                    exp_val.push_back('0);
                    set_uf = 1;
                end else begin
                    exp_val.push_back(mdl[s][msz[s]-1]);
                    if (op == 3'b001) msz[s]--;
                end
            end else if (op == 3'b010 || op == 3'b011) begin
                if (msz[s] == DEPTH) set_of = 1;
                else begin
                    mdl[s][msz[s]] = val;
                    msz[s]++;
                end
            end else if (op == 3'b100) begin
                lat = 1;
                exp_code.push_back(dest);
                exp_val.push_back(DW'(msz[s]));
            end else if (op == 3'b110) begin
                msz[s] = 0;
            end
        end
        m_of = set_of ? 1'b1 : (clr_e ? 1'b0 : m_of);
        m_uf = set_uf ? 1'b1 : (clr_e ? 1'b0 : m_uf);
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] id, input logic [DW-1:0] val,
                        input logic [7:0] dest, input bit clr_e);
        int n, lat;
        @(negedge clk);
        op_valid = 1'b1; op_code = op; op_stack_id = id;
        op_value = val; op_dest_code = dest; err_clear = clr_e;
        n = 0;
        while (!op_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) begin
            chk("op_ready_timeout", 0, 1);
            op_valid = 1'b0; err_clear = 1'b0;
            return;
        end
        model_accept(op, id, val, dest, clr_e, lat);
        @(posedge clk);
        #1;
        op_valid = 1'b0; err_clear = 1'b0;
        @(negedge clk);
        chk("count_flat", count_flat, exp_flat());
        chk("err_flags", {err_overflow, err_underflow}, {m_of, m_uf});
        if (lat > 0) begin
            n = 1;
            while (!wb_valid && n < 8) begin
                @(negedge clk);
                n++;
            end
            chk("wb_latency", n, lat);
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        m_of = 0; m_uf = 0;
        @(negedge clk);
        chk("err_clear", {err_overflow, err_underflow}, 2'b00);
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 0;
        while ((exp_code.size() != 0 || wb_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int r;
        logic [2:0] op, id;
        for (int i = 0; i < SC; i++) msz[i] = 0;
        m_of = 0; m_uf = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("op_ready_in_rst", op_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_wb", {wb_valid, wb_code, wb_value}, '0);
        chk("rst_counts", count_flat, '0);
        chk("rst_errs", {err_overflow, err_underflow}, 2'b00);

        // PUSHI then POP on stack 1
        send(3'b011, 3'd1, 32'h000ABC, 8'h00, 0);
        send(3'b001, 3'd1, 32'h0, 8'h05, 0);
        drain();

        // Fill stack 2, overflow, then LIFO drain
        for (int i = 1; i <= 16; i++) send(3'b010, 3'd2, DW'(i), 8'h00, 0);
        send(3'b010, 3'd2, 32'h99, 8'h00, 0);
        for (int i = 0; i < 16; i++) send(3'b001, 3'd2, 32'h0, 8'h40, 0);
        drain();
        clear_err();

        // Underflow, standalone clear, clear racing a new underflow
        send(3'b001, 3'd3, 32'h0, 8'h60, 0);
        drain();
        clear_err();
        send(3'b001, 3'd3, 32'h0, 8'h61, 1);
        drain();
        clear_err();

        // GSA with wb_ready held low
        for (int i = 0; i < 2; i++) send(3'b010, 3'd1, DW'(i + 7), 8'h00, 0);
        rdy_mode = 2;
        @(negedge clk);
        send(3'b100, 3'd1, 32'h0, 8'h22, 0);
        repeat (4) begin
            @(negedge clk);
            chk("gsa_op_ready_low", op_ready, 0);
        end
        drain();

        // PEEK, plus out-of-range stack IDs
        send(3'b110, 3'd1, 32'h0, 8'h00, 0);
        send(3'b010, 3'd1, 32'h1234, 8'h00, 0);
        send(3'b101, 3'd1, 32'h0, 8'h33, 0);
        send(3'b010, 3'd0, 32'h55, 8'h00, 0);
        send(3'b001, 3'd4, 32'h0, 8'h44, 0);
        send(3'b100, 3'd0, 32'h0, 8'h45, 0);
        drain();

        // Random traffic
        rdy_mode = 1;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 35) op = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b011;
            else if (r < 55) op = 3'b001;
            else if (r < 63) op = 3'b101;
            else if (r < 70) op = 3'b100;
            else if (r < 73) op = 3'b110;
            else if (r < 77) op = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b111;
            else op = 3'b010;
            id = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(1, 3));
            send(op, id, $urandom, 8'($urandom), ($urandom_range(0, 7) == 0));
        end
        drain();

        // Reset during the READ cycle of a POP
        send(3'b010, 3'd1, 32'hBEEF, 8'h00, 0);
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'b001; op_stack_id = 3'd1; op_dest_code = 8'h77;
        chk("pre_rst_ready", op_ready, 1);
        @(posedge clk);
        #1 op_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < SC; i++) msz[i] = 0;
        m_of = 0; m_uf = 0;
        exp_code.delete(); exp_val.delete();
        @(negedge clk);
        chk("rst_mid_wb_valid", wb_valid, 0);
        chk("rst_mid_counts", count_flat, '0);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_wb", wb_valid, 0);

        drain();
        chk("scoreboard_empty", exp_code.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
